orbit_position_gen: RTL and testbench

//  Generates one orbiting object's screen coordinates for the orbit renderer.

---
 rtl/orbit_position_gen.sv | 193 +++++++++++++++++++
 tb/tb_orbit_position_gen.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/orbit_position_gen.sv
// Orbit position generator: phase accumulator -> sin/cos lookup -> radius
// scaling -> centre offset and clamp, presented on a valid/ready output.
// sineTable is a combinational quarter-wave sine ROM in Q1.14 (peak 0x3FFF).

module sineTable (
   input  logic        [7:0]  angle,
   output logic signed [15:0] value
);
   // First quadrant of round(16383*sin(i*2*pi/256)), i = 0..64
   localparam logic [13:0] QTAB [0:64] = '{
      14'd0,     14'd402,   14'd804,   14'd1205,  14'd1606,  14'd2005,  14'd2404,  14'd2801,
      14'd3196,  14'd3590,  14'd3981,  14'd4370,  14'd4756,  14'd5139,  14'd5519,  14'd5896,
      14'd6270,  14'd6639,  14'd7005,  14'd7366,  14'd7723,  14'd8075,  14'd8423,  14'd8765,
      14'd9102,  14'd9433,  14'd9759,  14'd10079, 14'd10393, 14'd10701, 14'd11002, 14'd11297,
      14'd11585, 14'd11865, 14'd12139, 14'd12405, 14'd12664, 14'd12915, 14'd13159, 14'd13394,
      14'd13622, 14'd13841, 14'd14052, 14'd14255, 14'd14449, 14'd14634, 14'd14810, 14'd14978,
      14'd15136, 14'd15285, 14'd15425, 14'd15556, 14'd15678, 14'd15790, 14'd15892, 14'd15985,
      14'd16068, 14'd16142, 14'd16206, 14'd16260, 14'd16304, 14'd16339, 14'd16363, 14'd16378,
      14'd16383
   };

   logic [6:0]  addr_s;
   logic [13:0] mag_s;

   // Fold the angle into the first quadrant, then restore the sign
   always_comb begin
      addr_s = {1'b0, angle[5:0]};
      if (angle[6] == 1'b1) begin
         addr_s = 7'd64 - {1'b0, angle[5:0]};
      end else begin
         addr_s = {1'b0, angle[5:0]};
      end
      mag_s = QTAB[addr_s];
      if (angle[7] == 1'b1) begin
         value = -$signed({2'b00, mag_s});
      end else begin
         value = $signed({2'b00, mag_s});
      end
   end
endmodule

module orbit_position_gen #(
   parameter int PHASE_W  = 16,
   parameter int RADIUS_W = 10,
   parameter int COORD_W  = 11,
   parameter int CENTER_X = 320,
   parameter int CENTER_Y = 240
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                tick,
   input  logic [PHASE_W-1:0]  step,
   input  logic [RADIUS_W-1:0] radius,
   input  logic                out_ready,
   output logic                out_valid,
   output logic [COORD_W-1:0]  x_out,
   output logic [COORD_W-1:0]  y_out,
   output logic [7:0]          angle_out,
   output logic                tick_missed
);
   localparam int PROD_W    = 16 + RADIUS_W + 1;
   localparam int SUM_W     = PROD_W + 1;
   localparam int FRAC_W    = 14;
   localparam int COORD_MAX = (2 ** COORD_W) - 1;

   typedef enum logic [2:0] {IDLE, LOOKUP, MULT, SUM, HOLD} state_t;

   state_t                     state_r, state_s;
   logic [PHASE_W-1:0]         phase_r;
   logic [RADIUS_W-1:0]        radius_r;
   logic [7:0]                 ang_r;
   logic [7:0]                 lut_ang_s, cos_ang_s;
   logic signed [15:0]         sin_s, cos_s, sin_r, cos_r;
   logic signed [PROD_W-1:0]   ps_r, pc_r, dx_s, dy_s;
   logic signed [SUM_W-1:0]    x_wide_s, y_wide_s;
   logic [COORD_W-1:0]         x_pipe_r, y_pipe_r;

   // Saturate a wide signed coordinate into the visible unsigned range
   function automatic logic [COORD_W-1:0] clamp_coord(input logic signed [SUM_W-1:0] v);
      if (v[SUM_W-1] == 1'b1) begin
         return '0;
      end else if (v > $signed(SUM_W'(COORD_MAX))) begin
         return '1;
      end else begin
         return v[COORD_W-1:0];
      end
   endfunction

   assign lut_ang_s = phase_r[PHASE_W-1 -: 8];
   assign cos_ang_s = lut_ang_s + 8'h40;

   sineTable u_sin (.angle(lut_ang_s), .value(sin_s));
   sineTable u_cos (.angle(cos_ang_s), .value(cos_s));

   // Scale back from Q1.14 (floor) and offset from the centre; y grows downward
   always_comb begin
      dx_s     = pc_r >>> FRAC_W;
      dy_s     = ps_r >>> FRAC_W;
      x_wide_s = $signed(SUM_W'(CENTER_X) + {dx_s[PROD_W-1], dx_s});
      y_wide_s = $signed(SUM_W'(CENTER_Y) - {dy_s[PROD_W-1], dy_s});
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic: one pass through the pipeline per accepted tick
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (tick && enable) begin
               state_s = LOOKUP;
            end else begin
               state_s = IDLE;
            end
         end
         LOOKUP: state_s = MULT;
         MULT:   state_s = SUM;
         SUM:    state_s = HOLD;
         HOLD: begin
            if (out_valid && out_ready) begin
               state_s = IDLE;
            end else begin
               state_s = HOLD;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Datapath and output registers; HOLD loads the outputs on its first cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_r     <= '0;
         radius_r    <= '0;
         ang_r       <= 8'h00;
         sin_r       <= '0;
         cos_r       <= '0;
         ps_r        <= '0;
         pc_r        <= '0;
         x_pipe_r    <= '0;
         y_pipe_r    <= '0;
         out_valid   <= 1'b0;
         x_out       <= '0;
         y_out       <= '0;
         angle_out   <= 8'h00;
         tick_missed <= 1'b0;
      end else begin
         if (tick && (state_r != IDLE)) begin
            tick_missed <= 1'b1;
         end
         case (state_r)
            IDLE: begin
               if (tick && enable) begin
                  phase_r  <= phase_r + step;
                  radius_r <= radius;
               end
            end
            LOOKUP: begin
               sin_r <= sin_s;
               cos_r <= cos_s;
               ang_r <= lut_ang_s;
            end
            MULT: begin
               ps_r <= PROD_W'(sin_r) * PROD_W'($signed({1'b0, radius_r}));
               pc_r <= PROD_W'(cos_r) * PROD_W'($signed({1'b0, radius_r}));
            end
            SUM: begin
               x_pipe_r <= clamp_coord(x_wide_s);
               y_pipe_r <= clamp_coord(y_wide_s);
            end
            HOLD: begin
               if (!out_valid) begin
                  x_out     <= x_pipe_r;
                  y_out     <= y_pipe_r;
                  angle_out <= ang_r;
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: out_valid <= 1'b0;
         endcase
      end
   end
endmodule

// File: tb/tb_orbit_position_gen.sv
// Directed bench for orbit_position_gen with hand-computed expected values.

module tb_orbit_position_gen;
   logic        clk;
   logic        reset;
   logic        enable;
   logic        tick;
   logic [15:0] step;
   logic [9:0]  radius;
   logic        out_ready;
   logic        out_valid;
   logic [10:0] x_out;
   logic [10:0] y_out;
   logic [7:0]  angle_out;
   logic        tick_missed;

   int n_checks = 0;
   int n_pass   = 0;

   orbit_position_gen dut (
      .clk(clk), .reset(reset), .enable(enable), .tick(tick),
      .step(step), .radius(radius), .out_ready(out_ready),
      .out_valid(out_valid), .x_out(x_out), .y_out(y_out),
      .angle_out(angle_out), .tick_missed(tick_missed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Pulse tick for one cycle (called at a negedge)
   task automatic do_tick(input logic [15:0] s, input logic [9:0] r);
      step   = s;
      radius = r;
      tick   = 1'b1;
      @(negedge clk);
      tick   = 1'b0;
   endtask

   // Wait (bounded) for a result, check it, and let the handshake complete
   task automatic result(input string tag, input logic [7:0] ea, input int ex, input int ey);
      for (int i = 0; i < 12 && !out_valid; i++) @(negedge clk);
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_angle"}, angle_out, ea);
      check({tag, "_x"}, x_out, ex);
      check({tag, "_y"}, y_out, ey);
      @(negedge clk);
   endtask

   initial begin
      logic stable;
      reset = 1'b1; enable = 1'b1; tick = 1'b0;
      step = 16'h4000; radius = 10'd100; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_x", x_out, 0);
      check("rst_y", y_out, 0);
      check("rst_angle", angle_out, 0);
      check("rst_missed", tick_missed, 0);
      reset = 1'b0;
      @(negedge clk);

      // Exact latency; enable dropped mid-operation must not cancel the result
      do_tick(16'h4000, 10'd100);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      check("lat_early", out_valid, 0);
      @(negedge clk);
      check("lat_valid", out_valid, 1);
      check("t1_angle", angle_out, 8'h40);
      check("t1_x", x_out, 320);
      check("t1_y", y_out, 141);
      enable = 1'b1;
      @(negedge clk);
      check("t1_done", out_valid, 0);

      do_tick(16'h4000, 10'd100);
      result("t2", 8'h80, 220, 240);
      do_tick(16'h4000, 10'd100);
      result("t3a", 8'hC0, 320, 340);
      do_tick(16'h4000, 10'd100);
      result("t3_wrap", 8'h00, 419, 240);

      // Large radius pushes x below zero
      do_tick(16'h8000, 10'd1023);
      result("t4_clamp", 8'h80, 0, 240);

      // Zero step repeats the same angle
      do_tick(16'h0000, 10'd100);
      result("step0", 8'h80, 220, 240);

      // Tick while disabled in IDLE is ignored and not flagged
      enable = 1'b0;
      do_tick(16'h4000, 10'd100);
      repeat (6) @(negedge clk);
      check("dis_valid", out_valid, 0);
      check("dis_missed", tick_missed, 0);
      enable = 1'b1;

      // Back-pressure in HOLD with a busy tick
      out_ready = 1'b0;
      do_tick(16'h4000, 10'd100);
      for (int i = 0; i < 12 && !out_valid; i++) @(negedge clk);
      check("t5_angle", angle_out, 8'hC0);
      check("t5_x", x_out, 320);
      check("t5_y", y_out, 340);
      stable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick = (i == 2);
         @(negedge clk);
         if (!out_valid || x_out != 11'd320 || y_out != 11'd340 || angle_out != 8'hC0) stable = 1'b0;
      end
      tick = 1'b0;
      check("t5_stable", stable, 1);
      check("t5_missed", tick_missed, 1);
      out_ready = 1'b1;
      @(negedge clk);
      check("t5_release", out_valid, 0);
      do_tick(16'h4000, 10'd100);
      result("t5_noadv", 8'h00, 419, 240);

      // Reset during MULT
      do_tick(16'h4000, 10'd100);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("t6_valid", out_valid, 0);
      check("t6_x", x_out, 0);
      check("t6_y", y_out, 0);
      check("t6_missed", tick_missed, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      do_tick(16'h4000, 10'd100);
      result("t6_restart", 8'h40, 320, 141);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
